// File: rtl/counter_checker.sv
// counter_checker
//   Passive monitor that sits beside a binary `counter` or a one-hot
//   `ring_counter`. It samples the counter's `enabled` input and `value`
//   output on every rising clk edge, predicts the next value, and reports
//   deviations through a lock flag, a one-cycle error pulse and a saturating
//   8-bit error count.
//
//   Optional feature macro: COUNTER_CHECKER_STICKY_EN
//     defined   : error_sticky is a flop set by the first error, cleared by rst_n
//     undefined : error_sticky is tied to constant 0
//
//   Every output is driven directly by a flop, so there is no combinational
//   path from the inputs to the outputs.
module counter_checker #(
  parameter int WIDTH       = 4,  // observed value width, 2..16
  parameter int RING        = 0,  // 0: binary up-counter, 1: one-hot ring (rotate left)
  parameter int LOCK_CYCLES = 4   // consecutive matches before locked, 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enabled,
  input  logic [WIDTH-1:0] value,
  output logic             locked,
  output logic             error,
  output logic [7:0]       err_count,
  output logic             error_sticky
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter guards
  // ---------------------------------------------------------------------------
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("counter_checker: WIDTH must lie in 2..16");
  end
  if (RING != 0 && RING != 1) begin : g_bad_ring
    $error("counter_checker: RING must be 0 or 1");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 15) begin : g_bad_lock
    $error("counter_checker: LOCK_CYCLES must lie in 1..15");
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE  = 1'b0,  // waiting for a legal sample to acquire
    ST_TRACK = 1'b1   // predicting and checking every sample
  } state_t;

  localparam logic [3:0] LP_LOCK    = 4'(LOCK_CYCLES);
  localparam logic [7:0] LP_ERR_MAX = 8'hFF;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_ref;        // last accepted value
  logic             r_en;         // enabled as sampled on the previous edge
  logic [3:0]       r_good;       // consecutive matching checks, saturating
  logic             r_locked;
  logic             r_error;
  logic [7:0]       r_err_count;

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  state_t           w_state_next;
  logic             w_onehot;     // value has exactly one bit set
  logic             w_legal;      // value is acceptable for the checking mode
  logic [WIDTH-1:0] w_next_ref;   // successor of r_ref in the checking mode
  logic [WIDTH-1:0] w_exp;        // value predicted for this edge
  logic             w_match;
  logic [3:0]       w_good_inc;   // r_good + 1, clamped at LOCK_CYCLES
  logic             w_load;       // capture value/enabled into r_ref/r_en
  logic             w_err_hit;    // this edge detects an error
  logic [3:0]       w_good_d;
  logic             w_locked_d;
  logic [7:0]       w_err_count_d;

  // ---------------------------------------------------------------------------
  // Prediction datapath
  // ---------------------------------------------------------------------------
  // A word is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  assign w_onehot = (value != '0) &&
                    ((value & (value - WIDTH'(1))) == '0);

  // Binary mode accepts every value; ring mode accepts only one-hot words.
  assign w_legal = (RING == 0) ? 1'b1 : w_onehot;

  // Successor: rotate left for the ring, modulo-2^WIDTH increment for binary.
  assign w_next_ref = (RING != 0) ? {r_ref[WIDTH-2:0], r_ref[WIDTH-1]}
                                  : r_ref + WIDTH'(1);

  // The counter only advances on edges where its enable was high, and the
  // enable we saw last edge is the one that governed this edge's update.
  assign w_exp   = r_en ? w_next_ref : r_ref;
  assign w_match = (value == w_exp);

  assign w_good_inc = (r_good >= LP_LOCK) ? LP_LOCK : r_good + 4'd1;

  // The error counter holds at 255 rather than wrapping back to zero.
  assign w_err_count_d = (w_err_hit && (r_err_count != LP_ERR_MAX))
                         ? r_err_count + 8'd1
                         : r_err_count;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register: returns to IDLE asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create order races.
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: acquire on a legal sample, drop back on an illegal one.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives the net,
    // so no latch is inferred when a branch leaves it untouched.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_legal)  w_state_next = ST_TRACK;
      ST_TRACK: if (!w_legal) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: decide capture, error and lock-tracking updates for this edge.
  always_comb begin
    w_load     = 1'b0;
    w_err_hit  = 1'b0;
    w_good_d   = r_good;
    w_locked_d = r_locked;
    case (r_state)
      ST_IDLE: begin
        // Acquisition edge: no check is made, lock tracking restarts.
        w_good_d   = '0;
        w_locked_d = 1'b0;
        if (w_legal) begin
          w_load = 1'b1;
        end else begin
          w_err_hit = 1'b1;
        end
      end
      ST_TRACK: begin
        // The reference always follows the observed value, so a single
        // glitch costs one error and tracking resumes on the next edge.
        w_load = 1'b1;
        if (w_legal && w_match) begin
          w_good_d   = w_good_inc;
          w_locked_d = (w_good_inc == LP_LOCK);
        end else begin
          w_err_hit  = 1'b1;
          w_good_d   = '0;
          w_locked_d = 1'b0;
        end
      end
      default: begin
        w_good_d   = '0;
        w_locked_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  // Reference capture, lock tracking and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref       <= '0;
      r_en        <= 1'b0;
      r_good      <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_load) begin
        r_ref <= value;
        r_en  <= enabled;
      end
      r_good      <= w_good_d;
      r_locked    <= w_locked_d;
      r_error     <= w_err_hit;
      r_err_count <= w_err_count_d;
    end
  end

  assign locked    = r_locked;
  assign error     = r_error;
  assign err_count = r_err_count;

`ifdef COUNTER_CHECKER_STICKY_EN
  logic r_sticky;

  // Sticky flag: set together with the first error pulse, held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_err_hit) begin
      r_sticky <= 1'b1;
    end
  end

  assign error_sticky = r_sticky;
`else
  assign error_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker
//   Self-checking bench for counter_checker. One binary instance and one
//   ring instance (WIDTH=4, LOCK_CYCLES=4) share clock and reset. Each
//   stimulus step pushes the hand-derived expected outputs to a scoreboard
//   queue; after the sampling edge the scenario task pops the entry and
//   compares it against the DUT outputs.
module tb_counter_checker;

  localparam int W    = 4;
  localparam int LOCK = 4;

`ifdef COUNTER_CHECKER_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         b_enabled, r_enabled;
  logic [W-1:0] b_value,   r_value;
  logic         b_locked,  r_locked;
  logic         b_error,   r_error;
  logic [7:0]   b_err_count, r_err_count;
  logic         b_sticky,  r_sticky;

  // Expected outputs packed as {error, locked, err_count[7:0], error_sticky}.
  typedef struct {
    string      tag;
    bit         ring;
    logic [10:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  counter_checker #(.WIDTH(W), .RING(0), .LOCK_CYCLES(LOCK)) u_bin (
    .clk          (clk),
    .rst_n        (rst_n),
    .enabled      (b_enabled),
    .value        (b_value),
    .locked       (b_locked),
    .error        (b_error),
    .err_count    (b_err_count),
    .error_sticky (b_sticky)
  );

  counter_checker #(.WIDTH(W), .RING(1), .LOCK_CYCLES(LOCK)) u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .enabled      (r_enabled),
    .value        (r_value),
    .locked       (r_locked),
    .error        (r_error),
    .err_count    (r_err_count),
    .error_sticky (r_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [10:0] observed(input bit ring);
    if (ring) return {r_error, r_locked, r_err_count, r_sticky};
    return {b_error, b_locked, b_err_count, b_sticky};
  endfunction

  // Drive one sample before the edge, queue what the checker must report for it.
  task automatic drive(input bit ring, input logic [W-1:0] v, input logic en,
                       input logic e_err, input logic e_lck,
                       input logic [7:0] e_cnt, input string tag);
    sb_t e;
    @(negedge clk);
    if (ring) begin
      r_value   = v;
      r_enabled = en;
    end else begin
      b_value   = v;
      b_enabled = en;
    end
    e.tag  = tag;
    e.ring = ring;
    e.exp  = {e_err, e_lck, e_cnt, STICKY_ON && (e_cnt != 8'd0)};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between clock edges; the next posedge is edge 1.
  task automatic pulse_reset;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [10:0] got;
    rst_n     = 1'b1;
    b_value   = '0;
    b_enabled = 1'b0;
    r_value   = 4'b0001;
    r_enabled = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    for (int r = 0; r < 2; r++) begin
      got = observed(r[0]);
      n_tests++;
      if (got !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: got %b, want all zero", r, got);
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      got = observed(r[0]);
      n_tests++;
      if (got !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_held dut%0d: got %b, want all zero", r, got);
      end
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_bin_disabled;
    sb_t e;
    logic [10:0] got;
    pulse_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0, k >= 5, 8'd0, $sformatf("bin_disabled[%0d]", k));
      e = sb.pop_front();
      got = observed(e.ring);
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got err=%b lck=%b cnt=%0d stk=%b, want err=%b lck=%b cnt=%0d stk=%b",
                 e.tag, got[10], got[9], got[8:1], got[0], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
  endtask

  task automatic test_bin_wrap;
    sb_t e;
    logic [10:0] got;
    pulse_reset();
    for (int k = 1; k <= 18; k++) begin
      drive(1'b0, 4'((k - 1) % 16), 1'b1, 1'b0, k >= 5, 8'd0, $sformatf("bin_wrap[%0d]", k));
      e = sb.pop_front();
      got = observed(e.ring);
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got err=%b lck=%b cnt=%0d stk=%b, want err=%b lck=%b cnt=%0d stk=%b",
                 e.tag, got[10], got[9], got[8:1], got[0], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
  endtask

  task automatic test_glitch;
    sb_t e;
    logic [10:0] got;
    int tv[9] = '{0, 1, 2, 3, 4, 5, 9, 10, 11};
    bit tl[9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    pulse_reset();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b0, 4'(tv[k-1]), 1'b1, k == 7, tl[k-1], (k >= 7) ? 8'd1 : 8'd0,
            $sformatf("glitch[%0d]", k));
      e = sb.pop_front();
      got = observed(e.ring);
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got err=%b lck=%b cnt=%0d stk=%b, want err=%b lck=%b cnt=%0d stk=%b",
                 e.tag, got[10], got[9], got[8:1], got[0], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
  endtask

  // Counter that only advances when its enable was high, then a stall it should not have.
  task automatic test_enable_toggle;
    sb_t e;
    logic [10:0] got;
    int tv[10] = '{0, 1, 1, 2, 3, 3, 3, 4, 4, 4};
    bit te[10] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    bit tl[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    pulse_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 4'(tv[k-1]), te[k-1], k == 9, tl[k-1], (k >= 9) ? 8'd1 : 8'd0,
            $sformatf("enable_toggle[%0d]", k));
      e = sb.pop_front();
      got = observed(e.ring);
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got err=%b lck=%b cnt=%0d stk=%b, want err=%b lck=%b cnt=%0d stk=%b",
                 e.tag, got[10], got[9], got[8:1], got[0], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
  endtask

  task automatic test_ring_track;
    sb_t e;
    logic [10:0] got;
    int tv[8] = '{1, 2, 4, 8, 1, 6, 4, 8};
    bit tr[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    bit tl[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int tc[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    pulse_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 4'(tv[k-1]), 1'b1, tr[k-1], tl[k-1], 8'(tc[k-1]),
            $sformatf("ring_track[%0d]", k));
      e = sb.pop_front();
      got = observed(e.ring);
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got err=%b lck=%b cnt=%0d stk=%b, want err=%b lck=%b cnt=%0d stk=%b",
                 e.tag, got[10], got[9], got[8:1], got[0], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
  endtask

  // Illegal words while still acquiring: back-to-back errors, then a clean acquire.
  task automatic test_ring_idle_illegal;
    sb_t e;
    logic [10:0] got;
    int tv[4] = '{0, 3, 1, 2};
    bit tr[4] = '{1, 1, 0, 0};
    int tc[4] = '{1, 2, 2, 2};
    pulse_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'(tv[k-1]), 1'b1, tr[k-1], 1'b0, 8'(tc[k-1]),
            $sformatf("ring_idle[%0d]", k));
      e = sb.pop_front();
      got = observed(e.ring);
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got err=%b lck=%b cnt=%0d stk=%b, want err=%b lck=%b cnt=%0d stk=%b",
                 e.tag, got[10], got[9], got[8:1], got[0], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
  endtask

  task automatic test_saturation_and_reset;
    sb_t e;
    logic [10:0] got;
    pulse_reset();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "sat_acquire");
    e = sb.pop_front();
    got = observed(e.ring);
    n_tests++;
    if (got !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", e.tag, got, e.exp);
    end
    // enabled stays 0, so each sample must equal the previous one; alternate to miss every edge.
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, (i % 2 == 1) ? 4'd5 : 4'd0, 1'b0, 1'b1, 1'b0,
            (i > 255) ? 8'd255 : 8'(i), $sformatf("sat[%0d]", i));
      e = sb.pop_front();
      got = observed(e.ring);
      n_tests++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got err=%b lck=%b cnt=%0d stk=%b, want err=%b lck=%b cnt=%0d stk=%b",
                 e.tag, got[10], got[9], got[8:1], got[0], e.exp[10], e.exp[9], e.exp[8:1], e.exp[0]);
      end
    end
    // Mid-stream reset between edges must clear the outputs without waiting for clk.
    #1 rst_n = 1'b0;
    #1;
    got = observed(1'b0);
    n_tests++;
    if (got !== 11'd0) begin
      n_fail++;
      $display("FAIL midstream_reset: got %b, want all zero", got);
    end
    #1 rst_n = 1'b1;
    drive(1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0, "reacquire");
    e = sb.pop_front();
    got = observed(e.ring);
    n_tests++;
    if (got !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", e.tag, got, e.exp);
    end
    drive(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0, "after_reacquire");
    e = sb.pop_front();
    got = observed(e.ring);
    n_tests++;
    if (got !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", e.tag, got, e.exp);
    end
  endtask

  initial begin
    test_reset();
    test_bin_disabled();
    test_bin_wrap();
    test_glitch();
    test_enable_toggle();
    test_ring_track();
    test_ring_idle_illegal();
    test_saturation_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
